imem_loader: RTL and testbench

//  Program loader and write-side counterpart of the core's instruction fetch.

---
 rtl/imem_loader.sv | 177 +++++++++++++++++
 tb/tb_imem_loader.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot-time program loader: packs a big-endian byte stream into 32-bit words,
// writes them to consecutive instr_mem addresses and releases core reset once loaded.
module imem_loader #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  input  logic [7:0]    s_data,
  input  logic          s_last,
  output logic          s_ready,
  input  logic          reload,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          core_rst,
  output logic          done,
  output logic          err,
  output logic [AW:0]   word_count
);

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  state_t        state_q, state_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [AW-1:0] word_idx_q, word_idx_d;
  logic [AW:0]   word_cnt_q, word_cnt_d;
  logic [31:0]   asm_q, asm_d;
  logic          last_q, last_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          s_ready_q, s_ready_d;
  logic          we_q, we_d;
  logic          core_rst_q, core_rst_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          accept;

  assign accept = s_valid && s_ready_q;

  // State and datapath registers; outputs are registered from the next-state decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      byte_cnt_q <= 2'd0;
      word_idx_q <= '0;
      word_cnt_q <= '0;
      asm_q      <= 32'd0;
      last_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      s_ready_q  <= 1'b0;
      we_q       <= 1'b0;
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_idx_q <= word_idx_d;
      word_cnt_q <= word_cnt_d;
      asm_q      <= asm_d;
      last_q     <= last_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      s_ready_q  <= s_ready_d;
      we_q       <= we_d;
      core_rst_q <= core_rst_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Next-state, byte packing and counter updates.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_idx_d = word_idx_q;
    word_cnt_d = word_cnt_q;
    asm_d      = asm_q;
    last_d     = last_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    case (state_q)
      ST_INIT: begin
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (accept) begin
          case (byte_cnt_q)
            2'd0:    asm_d[31:24] = s_data;
            2'd1:    asm_d[23:16] = s_data;
            2'd2:    asm_d[15:8]  = s_data;
            default: asm_d[7:0]   = s_data;
          endcase
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (s_last && (byte_cnt_q != 2'd3)) begin
            // Misaligned end of program: drop the partial word.
            state_d    = ST_ERR;
            byte_cnt_d = 2'd0;
            asm_d      = 32'd0;
          end else if (byte_cnt_q == 2'd3) begin
            state_d = ST_WRITE;
            last_d  = s_last;
            addr_d  = word_idx_q;
            wdata_d = {asm_q[31:8], s_data};
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_WRITE: begin
        word_idx_d = word_idx_q + {{(AW-1){1'b0}}, 1'b1};
        if (word_cnt_q != FULL_CNT) begin
          word_cnt_d = word_cnt_q + {{AW{1'b0}}, 1'b1};
        end else begin
          word_cnt_d = word_cnt_q;
        end
        asm_d  = 32'd0;
        last_d = 1'b0;
        if (last_q) begin
          state_d = ST_DONE;
        end else if (word_idx_q == LAST_IDX) begin
          state_d = ST_ERR;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_DONE, ST_ERR: begin
        if (reload) begin
          state_d    = ST_INIT;
          byte_cnt_d = 2'd0;
          word_idx_d = '0;
          word_cnt_d = '0;
          asm_d      = 32'd0;
          last_d     = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Moore outputs decoded from the next state so they line up with the state register.
  always_comb begin
    s_ready_d  = (state_d == ST_LOAD);
    we_d       = (state_d == ST_WRITE);
    done_d     = (state_d == ST_DONE);
    err_d      = (state_d == ST_ERR);
    core_rst_d = (state_d != ST_DONE);
  end

  assign s_ready    = s_ready_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign core_rst   = core_rst_q;
  assign done       = done_q;
  assign err        = err_q;
  assign word_count = word_cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: alignment, latency, overflow,
// reload and mid-load reset scenarios with hand-computed expectations.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'd0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic        reload = 1'b0;
  logic        imem_we;
  logic [3:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        core_rst;
  logic        done;
  logic        err;
  logic [4:0]  word_count;

  int total = 0;
  int bad = 0;
  int overlap = 0;
  logic [3:0]  wq_addr[$];
  logic [31:0] wq_data[$];

  imem_loader #(.DEPTH(16), .AW(4)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready), .reload(reload), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .core_rst(core_rst), .done(done), .err(err),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  // Write-port monitor: records every write and any WRITE cycle with s_ready high.
  always @(negedge clk) begin
    if (imem_we) begin
      wq_addr.push_back(imem_addr);
      wq_data.push_back(imem_wdata);
      if (s_ready) overlap++;
    end
  end

  // Present one byte from a negedge; returns at the negedge after acceptance.
  task automatic send_byte(input logic [7:0] d, input logic l, output bit ok);
    s_valid = 1'b1; s_data = d; s_last = l; ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      if (s_ready) begin
        @(posedge clk);
        ok = 1'b1;
      end
      @(negedge clk);
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    total++; if (core_rst !== 1'b1) begin bad++; $display("FAIL reset_core_rst: got %b expected 1", core_rst); end
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL reset_s_ready: got %b expected 0", s_ready); end
    total++; if (imem_we !== 1'b0) begin bad++; $display("FAIL reset_imem_we: got %b expected 0", imem_we); end
    total++; if (done !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL reset_done_err: got %b%b expected 00", done, err); end
    total++; if (word_count !== 5'd0) begin bad++; $display("FAIL reset_word_count: got %0d expected 0", word_count); end
    rst_n = 1'b1;
    #1;
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL release_s_ready_early: got %b expected 0", s_ready); end
    @(posedge clk); @(posedge clk); @(negedge clk);
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL release_s_ready: got %b expected 1", s_ready); end
  endtask

  task automatic test_two_words(input bit toggle, input string tag);
    logic [7:0] bytes [8];
    bit ok, all_ok;
    bytes = '{8'h20, 8'h00, 8'h00, 8'h00, 8'h02, 8'h44, 8'h00, 8'h00};
    wq_addr.delete(); wq_data.delete(); overlap = 0; all_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_byte(bytes[i], (i == 7) ? 1'b1 : 1'b0, ok);
      all_ok &= ok;
      if (toggle && i != 7) @(negedge clk);
    end
    total++; if (!all_ok) begin bad++; $display("FAIL %s_handshake_timeout: got 0 expected 1", tag); end
    total++; if (imem_we !== 1'b1 || imem_addr !== 4'd1 || imem_wdata !== 32'h02440000)
      begin bad++; $display("FAIL %s_last_write_latency: got we=%b addr=%0d data=%h expected we=1 addr=1 data=02440000", tag, imem_we, imem_addr, imem_wdata); end
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL %s_ready_in_write: got %b expected 0", tag, s_ready); end
    @(negedge clk);
    total++; if (done !== 1'b1 || core_rst !== 1'b0) begin bad++; $display("FAIL %s_done: got done=%b core_rst=%b expected done=1 core_rst=0", tag, done, core_rst); end
    total++; if (word_count !== 5'd2) begin bad++; $display("FAIL %s_word_count: got %0d expected 2", tag, word_count); end
    total++; if (imem_we !== 1'b0 || imem_addr !== 4'd1 || imem_wdata !== 32'h02440000)
      begin bad++; $display("FAIL %s_hold_after_write: got we=%b addr=%0d data=%h expected we=0 addr=1 data=02440000", tag, imem_we, imem_addr, imem_wdata); end
    total++; if (wq_addr.size() != 2) begin bad++; $display("FAIL %s_write_count: got %0d expected 2", tag, wq_addr.size()); end
    else begin
      total++; if (wq_addr[0] !== 4'd0 || wq_data[0] !== 32'h20000000) begin bad++; $display("FAIL %s_write0: got %0d/%h expected 0/20000000", tag, wq_addr[0], wq_data[0]); end
      total++; if (wq_addr[1] !== 4'd1 || wq_data[1] !== 32'h02440000) begin bad++; $display("FAIL %s_write1: got %0d/%h expected 1/02440000", tag, wq_addr[1], wq_data[1]); end
    end
    total++; if (overlap != 0) begin bad++; $display("FAIL %s_ready_during_write: got %0d expected 0", tag, overlap); end
  endtask

  task automatic test_load();
    test_two_words(1'b0, "load");
  endtask

  task automatic test_toggle();
    pulse_reload();
    total++; if (core_rst !== 1'b1 || done !== 1'b0 || word_count !== 5'd0)
      begin bad++; $display("FAIL reload_clear: got core_rst=%b done=%b wc=%0d expected 1 0 0", core_rst, done, word_count); end
    test_two_words(1'b1, "toggle");
  endtask

  task automatic test_misaligned();
    bit ok1, ok2;
    pulse_reload();
    wq_addr.delete(); wq_data.delete();
    send_byte(8'hAA, 1'b0, ok1);
    send_byte(8'hBB, 1'b1, ok2);
    @(negedge clk);
    total++; if (!(ok1 && ok2)) begin bad++; $display("FAIL misaligned_handshake: got %b%b expected 11", ok1, ok2); end
    total++; if (err !== 1'b1 || core_rst !== 1'b1 || done !== 1'b0)
      begin bad++; $display("FAIL misaligned_err: got err=%b core_rst=%b done=%b expected 1 1 0", err, core_rst, done); end
    total++; if (wq_addr.size() != 0) begin bad++; $display("FAIL misaligned_no_write: got %0d expected 0", wq_addr.size()); end
  endtask

  task automatic test_overflow();
    bit ok, all_ok;
    logic [7:0] b;
    pulse_reload();
    wq_addr.delete(); wq_data.delete(); all_ok = 1'b1;
    for (int w = 0; w < 16; w++) begin
      for (int j = 0; j < 4; j++) begin
        b = 8'(4 * w + j);
        send_byte(b, 1'b0, ok);
        all_ok &= ok;
      end
    end
    total++; if (!all_ok) begin bad++; $display("FAIL overflow_handshake_timeout: got 0 expected 1"); end
    send_byte(8'hEE, 1'b0, ok);
    total++; if (ok) begin bad++; $display("FAIL overflow_byte_accepted: got 1 expected 0"); end
    total++; if (err !== 1'b1 || s_ready !== 1'b0) begin bad++; $display("FAIL overflow_err: got err=%b s_ready=%b expected 1 0", err, s_ready); end
    total++; if (word_count !== 5'd16) begin bad++; $display("FAIL overflow_word_count: got %0d expected 16", word_count); end
    total++; if (wq_addr.size() != 16) begin bad++; $display("FAIL overflow_write_count: got %0d expected 16", wq_addr.size()); end
    else begin
      for (int w = 0; w < 16; w++) begin
        logic [7:0] b0, b1, b2, b3;
        b0 = 8'(4 * w); b1 = 8'(4 * w + 1); b2 = 8'(4 * w + 2); b3 = 8'(4 * w + 3);
        total++;
        if (wq_addr[w] !== 4'(w) || wq_data[w] !== {b0, b1, b2, b3}) begin
          bad++; $display("FAIL overflow_write%0d: got %0d/%h expected %0d/%h", w, wq_addr[w], wq_data[w], w, {b0, b1, b2, b3});
        end
      end
    end
  endtask

  task automatic load_word(input logic [31:0] w, output bit all_ok);
    bit ok;
    all_ok = 1'b1;
    for (int j = 0; j < 4; j++) begin
      send_byte(w[31 - 8 * j -: 8], (j == 3) ? 1'b1 : 1'b0, ok);
      all_ok &= ok;
    end
    @(negedge clk);
  endtask

  task automatic test_reload();
    bit ok, all_ok;
    pulse_reload();
    load_word(32'hDEADBEEF, ok);
    total++; if (!ok || done !== 1'b1) begin bad++; $display("FAIL reload_setup_done: got ok=%b done=%b expected 1 1", ok, done); end
    pulse_reload();
    total++; if (core_rst !== 1'b1 || done !== 1'b0 || word_count !== 5'd0)
      begin bad++; $display("FAIL reload_from_done: got core_rst=%b done=%b wc=%0d expected 1 0 0", core_rst, done, word_count); end
    wq_addr.delete(); wq_data.delete(); all_ok = 1'b1;
    send_byte(8'h01, 1'b0, ok); all_ok &= ok;
    total++; if (core_rst !== 1'b1) begin bad++; $display("FAIL reload_core_rst_during_load: got %b expected 1", core_rst); end
    send_byte(8'h23, 1'b0, ok); all_ok &= ok;
    send_byte(8'h45, 1'b0, ok); all_ok &= ok;
    send_byte(8'h67, 1'b1, ok); all_ok &= ok;
    @(negedge clk);
    total++; if (!all_ok) begin bad++; $display("FAIL reload_handshake_timeout: got 0 expected 1"); end
    total++; if (wq_addr.size() != 1 || wq_addr[0] !== 4'd0 || wq_data[0] !== 32'h01234567)
      begin bad++; $display("FAIL reload_write: got n=%0d expected one write 0/01234567", wq_addr.size()); end
    total++; if (done !== 1'b1 || word_count !== 5'd1) begin bad++; $display("FAIL reload_done: got done=%b wc=%0d expected 1 1", done, word_count); end
  endtask

  task automatic test_midreset();
    bit ok1, ok2, ok3;
    pulse_reload();
    send_byte(8'h11, 1'b0, ok1);
    send_byte(8'h22, 1'b0, ok2);
    rst_n = 1'b0;
    #1;
    total++; if (core_rst !== 1'b1 || s_ready !== 1'b0 || word_count !== 5'd0)
      begin bad++; $display("FAIL midreset_async: got core_rst=%b s_ready=%b wc=%0d expected 1 0 0", core_rst, s_ready, word_count); end
    @(negedge clk);
    rst_n = 1'b1;
    wq_addr.delete(); wq_data.delete();
    load_word(32'hCAFEF00D, ok3);
    total++; if (!(ok1 && ok2 && ok3)) begin bad++; $display("FAIL midreset_handshake: got %b%b%b expected 111", ok1, ok2, ok3); end
    total++; if (wq_addr.size() != 1 || wq_addr[0] !== 4'd0 || wq_data[0] !== 32'hCAFEF00D)
      begin bad++; $display("FAIL midreset_write: got n=%0d expected one write 0/cafef00d", wq_addr.size()); end
    total++; if (done !== 1'b1 || word_count !== 5'd1) begin bad++; $display("FAIL midreset_done: got done=%b wc=%0d expected 1 1", done, word_count); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_toggle();
    test_misaligned();
    test_overflow();
    test_reload();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
